// File: rtl/dm_mem_mh.sv
// rtl/dm_mem_mh.sv - multi-hart debug memory with abstract-command sequencer
module dm_mem_mh #(
  parameter int unsigned        NrHarts         = 1,
  parameter int unsigned        BusWidth        = 32,
  parameter int unsigned        DataCount       = 2,
  parameter int unsigned        ProgBufSize     = 8,
  parameter logic [NrHarts-1:0] SelectableHarts = {NrHarts{1'b1}}
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     ndmreset_i,
  input  logic [19:0]              hartsel_i,
  input  logic [NrHarts-1:0]       haltreq_i,
  input  logic [NrHarts-1:0]       resumereq_i,
  input  logic                     clear_resumeack_i,
  output logic [NrHarts-1:0]       debug_req_o,
  output logic [NrHarts-1:0]       halted_o,
  output logic [NrHarts-1:0]       resuming_o,
  output logic [NrHarts-1:0]       exc_sticky_o,
  input  logic [32*ProgBufSize-1:0] progbuf_i,
  input  logic [32*DataCount-1:0]  data_i,
  output logic [32*DataCount-1:0]  data_o,
  output logic                     data_valid_o,
  input  logic                     cmd_valid_i,
  input  logic [319:0]             cmd_words_i,
  input  logic                     cmd_pbshortcut_i,
  input  logic                     cmd_unsupported_i,
  output logic                     cmderror_valid_o,
  output logic [2:0]               cmderror_o,
  output logic                     cmdbusy_o,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [BusWidth-1:0]      addr_i,
  input  logic [BusWidth-1:0]      wdata_i,
  input  logic [BusWidth/8-1:0]    be_i,
  output logic [BusWidth-1:0]      rdata_o,
  input  logic [BusWidth-1:0]      rom_rdata_i
);
  localparam int unsigned Lanes = BusWidth / 32;
  // Region bases in 32-bit word units (byte offset >> 2).
  localparam logic [9:0] HaltedW    = 10'h040;
  localparam logic [9:0] GoingW     = 10'h042;
  localparam logic [9:0] ResumingW  = 10'h044;
  localparam logic [9:0] ExceptionW = 10'h046;
  localparam logic [9:0] WhereToW   = 10'h0C0;
  localparam logic [9:0] DataW      = 10'h0E0;
  localparam logic [9:0] ProgBufW   = DataW - 10'(ProgBufSize);
  localparam logic [9:0] AbsCmdW    = ProgBufW - 10'd10;

  localparam logic [2:0] ErrNone = 3'd0, ErrNotSup = 3'd2, ErrExc = 3'd3, ErrHaltResume = 3'd4;
  localparam logic [1:0] StIdle = 2'd0, StGo = 2'd1, StExec = 2'd2, StResume = 3'd3;

  function automatic logic [NrHarts-1:0] hart_oh(input logic [19:0] idx);
    hart_oh = '0;
    for (int i = 0; i < int'(NrHarts); i++) if (idx == 20'(i)) hart_oh[i] = 1'b1;
  endfunction

  // Target is a halfword address; the jal sits at WhereTo (halfword 0x180).
  function automatic logic [31:0] jal_x0(input logic [10:0] target_hw);
    logic [19:0] imm;
    imm = {9'd0, target_hw} - 20'h180;
    return {imm[19], imm[9:0], imm[10], imm[18:11], 5'd0, 7'h6f};
  endfunction

  logic [NrHarts-1:0] halted_q, halted_d, resuming_q, resuming_d, exc_q, exc_d;
  logic [NrHarts-1:0] sel_oh, wr_oh;
  logic [1:0]  state_q, state_d;
  logic [2:0]  err_q, err_d;
  logic [9:0]  wa0;
  logic        wr, halted_we, going_we, resuming_we, exception_we;
  logic        halted_sel, resuming_sel, resumereq_sel, haltreq_sel;
  logic [32*DataCount-1:0] data_q, data_d;
  logic        data_hit, data_valid_q;
  logic [63:0] rd_d, rdata_q;
  logic [31:0] where_to;
  logic [9:0]  wa;
  logic        rom_q, addr2_q, go_flag, resume_flag;

  assign sel_oh        = hart_oh(hartsel_i);
  assign wr_oh         = hart_oh({15'd0, wdata_i[4:0]});
  assign halted_sel    = |(halted_q & sel_oh);
  assign resuming_sel  = |(resuming_q & sel_oh);
  assign resumereq_sel = |(resumereq_i & sel_oh);
  assign haltreq_sel   = |(haltreq_i & sel_oh);

  assign wa0          = addr_i[11:2] & ~10'(Lanes - 1);
  assign wr           = req_i & we_i & ~ndmreset_i;
  assign halted_we    = wr && (wa0 == HaltedW);
  assign going_we     = wr && (wa0 == GoingW);
  assign resuming_we  = wr && (wa0 == ResumingW);
  assign exception_we = wr && (wa0 == ExceptionW);

  // Set is applied after clear so a same-cycle Resuming write wins over clear_resumeack.
  always_comb begin
    halted_d   = halted_q;
    resuming_d = resuming_q;
    exc_d      = exc_q;
    if (clear_resumeack_i) resuming_d = resuming_d & ~sel_oh;
    if (halted_we) begin
      halted_d = halted_d | wr_oh;
      exc_d    = exc_d & ~wr_oh;
    end
    if (resuming_we) begin
      halted_d   = halted_d & ~wr_oh;
      resuming_d = resuming_d | wr_oh;
    end
    if (exception_we) exc_d = exc_d | sel_oh;
    if (ndmreset_i) begin
      halted_d   = '0;
      resuming_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = ErrNone;
    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          if (cmd_unsupported_i) err_d = ErrNotSup;
          else if (halted_sel)   state_d = StGo;
          else                   err_d = ErrHaltResume;
        end else if (resumereq_sel && !resuming_sel && !haltreq_sel && halted_sel) begin
          state_d = StResume;
        end
      end
      StGo:     if (going_we) state_d = StExec;
      StExec:   if (halted_we) state_d = StIdle;
      StResume: if (resuming_sel) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (exception_we) err_d = ErrExc;
    if (ndmreset_i) begin
      state_d = StIdle;
      err_d   = ErrNone;
    end
  end

  // data_o snapshots data_i with the hart's bytes merged, for the CSRs to latch on data_valid_o.
  always_comb begin
    data_d   = data_i;
    data_hit = 1'b0;
    for (int i = 0; i < int'(DataCount); i++) begin
      for (int l = 0; l < int'(Lanes); l++) begin
        if (wr && (wa0 + 10'(l) == DataW + 10'(i))) begin
          data_hit = 1'b1;
          for (int b = 0; b < 4; b++)
            if (be_i[4*l+b]) data_d[32*i+8*b +: 8] = wdata_i[32*l+8*b +: 8];
        end
      end
    end
  end

  assign go_flag     = (state_q == StGo);
  assign resume_flag = (state_q == StResume);

  always_comb begin
    where_to = '0;
    if (state_q == StGo || state_q == StExec)
      where_to = cmd_pbshortcut_i ? jal_x0({ProgBufW, 1'b0}) : jal_x0({AbsCmdW, 1'b0});
    else if (resumereq_sel)
      where_to = jal_x0(11'h404);
  end

  always_comb begin
    rd_d = '0;
    wa   = '0;
    for (int k = 0; k < 2; k++) begin
      wa = {addr_i[11:3], 1'(k)};
      if (wa == WhereToW) rd_d[32*k +: 32] = where_to;
      for (int i = 0; i < int'(DataCount); i++)
        if (wa == DataW + 10'(i)) rd_d[32*k +: 32] = data_i[32*i +: 32];
      for (int i = 0; i < int'(ProgBufSize); i++)
        if (wa == ProgBufW + 10'(i)) rd_d[32*k +: 32] = progbuf_i[32*i +: 32];
      for (int i = 0; i < 10; i++)
        if (wa == AbsCmdW + 10'(i)) rd_d[32*k +: 32] = cmd_words_i[32*i +: 32];
    end
    if (addr_i[11:10] == 2'b01) begin
      for (int b = 0; b < 8; b++)
        if ({10'd0, addr_i[9:3], 3'(b)} == hartsel_i) rd_d[8*b +: 8] = {6'd0, resume_flag, go_flag};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      halted_q     <= '0;
      resuming_q   <= '0;
      exc_q        <= '0;
      state_q      <= StIdle;
      err_q        <= ErrNone;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      rdata_q      <= '0;
      rom_q        <= 1'b0;
      addr2_q      <= 1'b0;
    end else begin
      halted_q     <= halted_d & SelectableHarts;
      resuming_q   <= resuming_d & SelectableHarts;
      exc_q        <= exc_d & SelectableHarts;
      state_q      <= state_d;
      err_q        <= err_d;
      data_valid_q <= data_hit;
      if (data_hit) data_q <= data_d;
      if (req_i) begin
        rdata_q <= rd_d;
        rom_q   <= addr_i[11];
        addr2_q <= addr_i[2];
      end
    end
  end

  if (BusWidth == 64) begin : g_bus64
    assign rdata_o = rom_q ? rom_rdata_i : rdata_q;
  end else begin : g_bus32
    assign rdata_o = rom_q ? rom_rdata_i : (addr2_q ? rdata_q[63:32] : rdata_q[31:0]);
  end

  logic unused_ok;
  assign unused_ok = ^{addr_i[BusWidth-1:12], addr_i[1:0], addr2_q};

  assign debug_req_o      = haltreq_i & SelectableHarts;
  assign halted_o         = halted_q;
  assign resuming_o       = resuming_q;
  assign exc_sticky_o     = exc_q;
  assign data_o           = data_q;
  assign data_valid_o     = data_valid_q;
  assign cmderror_o       = err_q;
  assign cmderror_valid_o = |err_q;
  assign cmdbusy_o        = (state_q != StIdle);
endmodule

// File: tb/tb_dm_mem_mh.sv
// tb/tb_dm_mem_mh.sv - scoreboard bench for dm_mem_mh (32-bit and 64-bit bus instances)
module tb_dm_mem_mh;
  localparam int NH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ni, ndmreset, clear_resumeack, cmd_valid, cmd_pbshortcut, cmd_unsupported;
  logic [19:0] hartsel;
  logic [NH-1:0] haltreq, resumereq;
  logic [255:0] progbuf;
  logic [319:0] cmd_words;
  logic [63:0] data_a;
  logic [95:0] data_b;

  logic req_a, we_a, dv_a, errv_a, busy_a;
  logic [31:0] addr_a, wdata_a, rdata_a, rom_rdata_a;
  logic [3:0] be_a;
  logic [2:0] err_a;
  logic [NH-1:0] dbg_a, halted_a, resuming_a, exc_a;
  logic [63:0] data_o_a;

  logic req_b, we_b, dv_b, errv_b, busy_b;
  logic [63:0] addr_b, wdata_b, rdata_b, rom_rdata_b;
  logic [7:0] be_b;
  logic [2:0] err_b;
  logic [NH-1:0] dbg_b, halted_b, resuming_b, exc_b;
  logic [95:0] data_o_b;

  dm_mem_mh #(.NrHarts(NH), .BusWidth(32), .DataCount(2), .ProgBufSize(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .ndmreset_i(ndmreset), .hartsel_i(hartsel),
    .haltreq_i(haltreq), .resumereq_i(resumereq), .clear_resumeack_i(clear_resumeack),
    .debug_req_o(dbg_a), .halted_o(halted_a), .resuming_o(resuming_a), .exc_sticky_o(exc_a),
    .progbuf_i(progbuf), .data_i(data_a), .data_o(data_o_a), .data_valid_o(dv_a),
    .cmd_valid_i(cmd_valid), .cmd_words_i(cmd_words), .cmd_pbshortcut_i(cmd_pbshortcut),
    .cmd_unsupported_i(cmd_unsupported), .cmderror_valid_o(errv_a), .cmderror_o(err_a),
    .cmdbusy_o(busy_a), .req_i(req_a), .we_i(we_a), .addr_i(addr_a), .wdata_i(wdata_a),
    .be_i(be_a), .rdata_o(rdata_a), .rom_rdata_i(rom_rdata_a));

  dm_mem_mh #(.NrHarts(NH), .BusWidth(64), .DataCount(3), .ProgBufSize(8)) dut64 (
    .clk_i(clk), .rst_ni(rst_ni), .ndmreset_i(ndmreset), .hartsel_i(hartsel),
    .haltreq_i(haltreq), .resumereq_i(resumereq), .clear_resumeack_i(clear_resumeack),
    .debug_req_o(dbg_b), .halted_o(halted_b), .resuming_o(resuming_b), .exc_sticky_o(exc_b),
    .progbuf_i(progbuf), .data_i(data_b), .data_o(data_o_b), .data_valid_o(dv_b),
    .cmd_valid_i(cmd_valid), .cmd_words_i(cmd_words), .cmd_pbshortcut_i(cmd_pbshortcut),
    .cmd_unsupported_i(cmd_unsupported), .cmderror_valid_o(errv_b), .cmderror_o(err_b),
    .cmdbusy_o(busy_b), .req_i(req_b), .we_i(we_b), .addr_i(addr_b), .wdata_i(wdata_b),
    .be_i(be_b), .rdata_o(rdata_b), .rom_rdata_i(rom_rdata_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [63:0] exp;
    bit          b64;
  } rd_t;
  rd_t rd_q[$];

  task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp, input bit b64 = 1'b0);
    rd_t e;
    @(negedge clk);
    if (b64) begin req_b = 1'b1; we_b = 1'b0; addr_b = {52'd0, a}; end
    else     begin req_a = 1'b1; we_a = 1'b0; addr_a = {20'd0, a}; end
    e.tag = tag; e.exp = exp; e.b64 = b64;
    rd_q.push_back(e);
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    e = rd_q.pop_front();
    chk(e.tag, e.b64 ? rdata_b : {32'd0, rdata_a}, e.exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d, input logic [7:0] be, input bit b64 = 1'b0);
    @(negedge clk);
    if (b64) begin req_b = 1'b1; we_b = 1'b1; addr_b = {52'd0, a}; wdata_b = d; be_b = be; end
    else     begin req_a = 1'b1; we_a = 1'b1; addr_a = {20'd0, a}; wdata_a = d[31:0]; be_a = be[3:0]; end
    @(posedge clk); #1;
    req_a = 1'b0; we_a = 1'b0; req_b = 1'b0; we_b = 1'b0;
  endtask

  task automatic cmd(input logic unsup);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_unsupported = unsup;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_unsupported = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; ndmreset = 1'b0; hartsel = 20'd2; haltreq = '0; resumereq = '0;
    clear_resumeack = 1'b0; cmd_valid = 1'b0; cmd_pbshortcut = 1'b0; cmd_unsupported = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0; be_a = '0; rom_rdata_a = 32'hCAFE_F00D;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0; be_b = '0; rom_rdata_b = '0;
    for (int i = 0; i < 8; i++)  progbuf[32*i +: 32]   = 32'hB000_0000 + i;
    for (int i = 0; i < 10; i++) cmd_words[32*i +: 32] = 32'hC000_0000 + i;
    for (int i = 0; i < 2; i++)  data_a[32*i +: 32]    = 32'hD000_0000 + i;
    for (int i = 0; i < 3; i++)  data_b[32*i +: 32]    = 32'hE000_0000 + i;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_halted", halted_a, 0);
    chk("rst_resuming", resuming_a, 0);
    chk("rst_exc", exc_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_errv", errv_a, 0);
    chk("rst_dv", dv_a, 0);
    chk("rst_rdata", rdata_a, 0);
    @(negedge clk); rst_ni = 1'b1;

    @(negedge clk); haltreq = 4'b0100; #1;
    chk("debug_req", dbg_a, 4'b0100);
    haltreq = '0;

    // Command flow on hart 2
    wr(12'h100, 64'd2, 8'hF);
    chk("halted_set", halted_a, 4'b0100);
    chk("exc_clear", exc_a, 0);
    cmd(1'b0);
    chk("busy_go", busy_a, 1);
    chk("no_err_go", errv_a, 0);
    rd("whereto_abscmd", 12'h300, 64'h0380_006F);
    cmd_pbshortcut = 1'b1;
    rd("whereto_progbuf", 12'h300, 64'h0600_006F);
    cmd_pbshortcut = 1'b0;
    rd("flags_go", 12'h402, 64'h0001_0000);
    rd("flags_upper", 12'h404, 64'h0);
    rd("data0", 12'h380, 64'hD000_0000);
    rd("data1", 12'h384, 64'hD000_0001);
    rd("progbuf0", 12'h360, 64'hB000_0000);
    rd("progbuf7", 12'h37C, 64'hB000_0007);
    rd("abscmd0", 12'h338, 64'hC000_0000);
    rd("abscmd9", 12'h35C, 64'hC000_0009);
    rd("unmapped", 12'h200, 64'h0);
    rd("rom", 12'h800, 64'hCAFE_F00D);
    wr(12'h108, 64'd0, 8'hF);
    chk("busy_exec", busy_a, 1);
    rd("flags_exec", 12'h402, 64'h0);
    wr(12'h100, 64'd2, 8'hF);
    chk("idle_after_halted", busy_a, 0);

    // Resume flow on hart 0
    hartsel = 20'd0;
    wr(12'h100, 64'd0, 8'hF);
    chk("halted_two", halted_a, 4'b0101);
    @(negedge clk); resumereq = 4'b0001;
    tick();
    chk("busy_resume", busy_a, 1);
    rd("whereto_resume", 12'h300, 64'h5080_006F);
    rd("flags_resume", 12'h400, 64'h0000_0002);
    wr(12'h110, 64'd0, 8'hF);
    chk("resuming_set", resuming_a, 4'b0001);
    chk("halted_cleared", halted_a, 4'b0100);
    @(negedge clk); resumereq = '0;
    tick();
    chk("idle_after_resume", busy_a, 0);
    @(negedge clk); clear_resumeack = 1'b1;
    tick();
    clear_resumeack = 1'b0;
    chk("resumeack_cleared", resuming_a, 0);
    clear_resumeack = 1'b1;
    wr(12'h110, 64'd0, 8'hF);
    clear_resumeack = 1'b0;
    chk("resuming_set_wins", resuming_a, 4'b0001);

    // Exception during Exec, then ndmreset
    hartsel = 20'd2;
    cmd(1'b0);
    wr(12'h108, 64'd0, 8'hF);
    wr(12'h118, 64'd0, 8'hF);
    chk("exc_errv", errv_a, 1);
    chk("exc_code", err_a, 3);
    chk("exc_sticky", exc_a, 4'b0100);
    tick();
    chk("err_one_cycle", errv_a, 0);
    @(negedge clk); ndmreset = 1'b1;
    tick();
    ndmreset = 1'b0;
    chk("ndm_halted", halted_a, 0);
    chk("ndm_resuming", resuming_a, 0);
    chk("ndm_busy", busy_a, 0);
    chk("ndm_exc_kept", exc_a, 4'b0100);

    // Command to a hart that is not halted
    hartsel = 20'd1;
    cmd(1'b0);
    chk("hr_errv", errv_a, 1);
    chk("hr_code", err_a, 4);
    chk("hr_idle", busy_a, 0);
    tick();
    chk("hr_one_cycle", errv_a, 0);

    // Unsupported, and exception taking priority in the same cycle
    hartsel = 20'd2;
    wr(12'h100, 64'd2, 8'hF);
    chk("exc_cleared_by_halted", exc_a, 0);
    cmd(1'b1);
    chk("unsup_code", err_a, 2);
    chk("unsup_idle", busy_a, 0);
    cmd_valid = 1'b1; cmd_unsupported = 1'b1;
    wr(12'h118, 64'd0, 8'hF);
    cmd_valid = 1'b0; cmd_unsupported = 1'b0;
    chk("prio_code", err_a, 3);

    // Out-of-range hart index is ignored
    wr(12'h100, 64'd5, 8'hF);
    chk("hart_oob_5", halted_a, 4'b0100);
    wr(12'h100, 64'd4, 8'hF);
    chk("hart_oob_4", halted_a, 4'b0100);

    // Data writes, 32-bit bus
    wr(12'h384, 64'hAAAA_BBBB, 8'h03);
    chk("a_dv", dv_a, 1);
    chk("a_data1_merge", data_o_a[63:32], 32'hD000_BBBB);
    chk("a_data0_snap", data_o_a[31:0], 32'hD000_0000);
    tick();
    chk("a_dv_one_cycle", dv_a, 0);

    // Data writes, 64-bit bus with DataCount=3
    wr(12'h388, 64'h1111_2222_3333_4444, 8'hFF, 1'b1);
    chk("b_dv", dv_b, 1);
    chk("b_data2_lower", data_o_b[95:64], 32'h3333_4444);
    chk("b_data10_snap", data_o_b[63:0], 64'hE000_0001_E000_0000);
    wr(12'h380, 64'h1111_2222_3333_4444, 8'hF0, 1'b1);
    chk("b_data1_upper", data_o_b[63:32], 32'h1111_2222);
    chk("b_data0_keep", data_o_b[31:0], 32'hE000_0000);
    rd("b_data_pair", 12'h380, 64'hE000_0001_E000_0000, 1'b1);

    // Reset in the middle of a command
    cmd(1'b0);
    chk("busy_before_rst", busy_a, 1);
    @(negedge clk); rst_ni = 1'b0; #1;
    chk("busy_async_rst", busy_a, 0);
    chk("halted_async_rst", halted_a, 0);
    @(negedge clk); rst_ni = 1'b1;
    tick();
    chk("no_pulse_after_rst", errv_a, 0);
    chk("idle_after_rst", busy_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
